// File: rtl/dac_sample_scheduler_pkg.sv
// Shared types for the DAC sample scheduler: sample word, scheduler states, mid-scale constant.
package dac_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

    localparam sample_t MIDSCALE = '0;

endpackage

// File: rtl/dac_sample_scheduler_fifo.sv
// Synchronous first-word-fall-through FIFO; clear has priority over push and pop.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/dac_sample_scheduler.sv
// Buffers upstream samples and releases one per enabled sample-rate strobe into the CIC/DAC chain.
// Handshake: a sample transfers on any clock edge where s_valid && s_ready; s_ready depends only on registered state/level.
module dac_sample_scheduler
    import dac_pkg::*;
#(
    parameter int BITLEN        = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int PRIME_LEVEL   = 4,
    parameter int UNDERRUN_HOLD = 0,
    parameter int CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          stop,
    input  logic signed [BITLEN-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic signed [BITLEN-1:0]      out_sample,
    output logic                          out_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              underrun_cnt,
    output sched_state_t                  dbg_state
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    sched_state_t            r_state;
    logic signed [BITLEN-1:0] r_out_sample;
    logic                    r_out_valid;
    logic [CNT_W-1:0]        r_underrun_cnt;

    logic                    w_stb;
    logic                    w_active;
    logic                    w_stop;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_underrun;
    logic [LW-1:0]           w_level;
    logic [BITLEN-1:0]       w_head;

    assign w_stb    = tick && ena;
    assign w_active = (r_state == PRIME) || (r_state == RUN);
    assign w_stop   = stop && w_active;
    assign s_ready  = w_active && (w_level < FULL_LVL);
    assign w_push   = s_valid && s_ready;

    // stop outranks the strobe, so a pop is only considered when no stop is pending.
    assign w_pop = w_active && !stop && w_stb &&
                   (((r_state == PRIME) && (w_level >= PRIME_LVL)) ||
                    ((r_state == RUN) && (w_level != '0)));
    assign w_underrun = (r_state == RUN) && !stop && w_stb && (w_level == '0);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BITLEN)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_stop),
        .i_din   (s_data),
        .o_dout  (w_head),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_out_sample   <= '0;
            r_out_valid    <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= PRIME;
                    end
                end
                PRIME, RUN: begin
                    if (w_stop) begin
                        r_state      <= FLUSH;
                        r_out_sample <= BITLEN'(MIDSCALE);
                        r_out_valid  <= 1'b1;
                    end else if (w_pop) begin
                        r_state      <= RUN;
                        r_out_sample <= w_head;
                        r_out_valid  <= 1'b1;
                    end else if (w_underrun) begin
                        r_state     <= PRIME;
                        r_out_valid <= 1'b1;
                        if (UNDERRUN_HOLD == 0) begin
                            r_out_sample <= BITLEN'(MIDSCALE);
                        end
                        if (r_underrun_cnt != '1) begin
                            r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_sample   = r_out_sample;
    assign out_valid    = r_out_valid;
    assign busy         = (r_state != IDLE);
    assign fifo_level   = w_level;
    assign underrun_cnt = r_underrun_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: expected samples are queued at each strobe and checked by a monitor.
module tb_dac_sample_scheduler;
    import dac_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic               tick;
    logic               start;
    logic               stop;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               busy;
    logic [3:0]         fifo_level;
    logic [15:0]        underrun_cnt;
    sched_state_t       dbg_state;

    logic [15:0]        out_u;
    logic [15:0]        exp_q[$];
    int                 n_checks = 0;
    int                 n_fails  = 0;

    assign out_u = out_sample;

    dac_sample_scheduler #(
        .BITLEN        (16),
        .FIFO_DEPTH    (8),
        .PRIME_LEVEL   (4),
        .UNDERRUN_HOLD (0),
        .CNT_W         (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .tick         (tick),
        .start        (start),
        .stop         (stop),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .dbg_state    (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every out_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL out_valid_unexpected: got out_sample 0x%0h, required no strobe at %0t", out_u, $time);
            end else begin
                chk("out_sample", {16'h0, out_u}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        logic rdy;
        bit   done;
        done    = 1'b0;
        s_data  = v;
        s_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            rdy = s_ready;
            step();
            if (rdy) done = 1'b1;
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_tick(input logic [15:0] e, input bit expect_out);
        if (expect_out) exp_q.push_back(e);
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_sample"}, {16'h0, out_u}, 32'h0);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_s_ready"}, {31'h0, s_ready}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_level"}, {28'h0, fifo_level}, 32'h0);
        chk({tag, "_underrun"}, {16'h0, underrun_cnt}, 32'h0);
        chk({tag, "_state"}, {30'h0, dbg_state}, {30'h0, IDLE});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ena = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
        s_valid = 1'b0; s_data = '0;
        #12;
        chk_reset_values("rst_hold");
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        chk_reset_values("post_rst");

        // basic playback with priming
        start = 1'b1; step(); start = 1'b0;
        chk("start_busy", {31'h0, busy}, 32'h1);
        chk("start_state", {30'h0, dbg_state}, {30'h0, PRIME});
        chk("prime_s_ready", {31'h0, s_ready}, 32'h1);
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
        chk("primed_level", {28'h0, fifo_level}, 32'd4);
        chk("prime_holds_out", {16'h0, out_u}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            do_tick(16'h0100 + 16'(i), 1'b1);
            chk("pop_out_valid", {31'h0, out_valid}, 32'h1);
            chk("pop_state_run", {30'h0, dbg_state}, {30'h0, RUN});
            step();
            chk("pop_valid_one_cycle", {31'h0, out_valid}, 32'h0);
            repeat (14) step();
        end
        chk("drained_level", {28'h0, fifo_level}, 32'd0);
        chk("held_between_strobes", {16'h0, out_u}, 32'h0103);

        // underrun in RUN
        do_tick(16'h0000, 1'b1);
        chk("underrun_valid", {31'h0, out_valid}, 32'h1);
        chk("underrun_cnt", {16'h0, underrun_cnt}, 32'd1);
        chk("underrun_state", {30'h0, dbg_state}, {30'h0, PRIME});
        chk("underrun_out", {16'h0, out_u}, 32'h0);
        push(16'h8000); push(16'hFFFF); push(16'h7FFF); push(16'h0203);
        do_tick(16'h8000, 1'b1);
        chk("resume_state", {30'h0, dbg_state}, {30'h0, RUN});
        chk("resume_level", {28'h0, fifo_level}, 32'd3);

        // ena low: strobes ignored, pushes accepted to full
        ena = 1'b0;
        repeat (3) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("ena_low_out_held", {16'h0, out_u}, 32'h8000);
        chk("ena_low_level", {28'h0, fifo_level}, 32'd3);
        for (int i = 4; i < 9; i++) push(16'h0200 + 16'(i));
        chk("full_level", {28'h0, fifo_level}, 32'd8);
        chk("full_s_ready", {31'h0, s_ready}, 32'h0);
        ena = 1'b1;

        // full FIFO: strobe pops, offered sample waits for s_ready
        s_data = 16'h0209; s_valid = 1'b1;
        do_tick(16'hFFFF, 1'b1);
        chk("full_pop_level", {28'h0, fifo_level}, 32'd7);
        chk("full_pop_s_ready", {31'h0, s_ready}, 32'h1);
        step();
        s_valid = 1'b0;
        chk("refill_level", {28'h0, fifo_level}, 32'd8);
        do_tick(16'h7FFF, 1'b1);
        s_data = 16'h020A; s_valid = 1'b1;
        do_tick(16'h0203, 1'b1);
        s_valid = 1'b0;
        chk("push_pop_level", {28'h0, fifo_level}, 32'd7);
        do_tick(16'h0204, 1'b1);
        do_tick(16'h0205, 1'b1);
        chk("pre_stop_level", {28'h0, fifo_level}, 32'd5);

        // stop together with a strobe
        exp_q.push_back(16'h0000);
        stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
        chk("flush_valid", {31'h0, out_valid}, 32'h1);
        chk("flush_level", {28'h0, fifo_level}, 32'd0);
        chk("flush_state", {30'h0, dbg_state}, {30'h0, FLUSH});
        chk("flush_s_ready", {31'h0, s_ready}, 32'h0);
        step();
        chk("after_flush_busy", {31'h0, busy}, 32'h0);
        chk("after_flush_state", {30'h0, dbg_state}, {30'h0, IDLE});
        stop = 1'b1; step(); stop = 1'b0;
        chk("idle_stop_ignored", {30'h0, dbg_state}, {30'h0, IDLE});
        do_tick(16'h0000, 1'b0);
        chk("idle_tick_ignored", {31'h0, out_valid}, 32'h0);
        chk("underrun_kept", {16'h0, underrun_cnt}, 32'd1);

        // priming threshold, then async reset mid-RUN
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h0300 + 16'(i));
        do_tick(16'h0000, 1'b0);
        chk("below_prime_no_pop", {31'h0, out_valid}, 32'h0);
        chk("below_prime_level", {28'h0, fifo_level}, 32'd3);
        push(16'h0303);
        do_tick(16'h0300, 1'b1);
        chk("prime_again_run", {30'h0, dbg_state}, {30'h0, RUN});
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_values("async_rst");
        step();
        rst = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i));
        do_tick(16'h0400, 1'b1);
        chk("post_rst_run", {30'h0, dbg_state}, {30'h0, RUN});
        chk("post_rst_level", {28'h0, fifo_level}, 32'd3);

        repeat (3) step();
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
